mode_countdown_timer: RTL

//  Downstream consumer of the mode FSM. Watches mode_state and runs the hurricane
//  (mode 3) and self-clean (mode 4) countdowns, 1 s resolution.

---
 rtl/mode_countdown_timer_pkg.sv | 30 +++
 rtl/mode_countdown_timer_bin8_to_bcd.sv | 27 ++
 rtl/mode_countdown_timer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mode_countdown_timer_pkg.sv
// Shared definitions for the hood mode countdown timer: mode encodings
// driven by the mode FSM, timer state codes and small width helpers.
package mode_countdown_timer_pkg;

   typedef enum logic [2:0] {
      MODE_STANDBY    = 3'd0,
      MODE_GEAR1      = 3'd1,
      MODE_GEAR2      = 3'd2,
      MODE_HURRICANE  = 3'd3,
      MODE_CLEAN      = 3'd4,
      MODE_INFO_TEMP  = 3'd5,
      MODE_INFO_HOURS = 3'd6,
      MODE_INFO_CUMUL = 3'd7
   } mode_t;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN_HUR  = 2'd1,
      ST_RUN_CLN  = 2'd2,
      ST_HUR_DONE = 2'd3
   } timer_state_t;

   localparam int unsigned BCD_W = 4;

   // Counter width able to hold 0..n-1, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mode_countdown_timer_bin8_to_bcd.sv
// Combinational 8-bit binary to three-digit BCD converter (double dabble).
module bin8_to_bcd
   import mode_countdown_timer_pkg::*;
(
   input  logic [7:0]       bin,
   output logic [BCD_W-1:0] hundreds,
   output logic [BCD_W-1:0] tens,
   output logic [BCD_W-1:0] ones
);

   logic [19:0] sh;

   // Shift-and-add-3: adjust every BCD column above 4 before each shift.
   always_comb begin
      sh = {12'd0, bin};
      for (int i = 0; i < 8; i++) begin
         if (sh[11:8]  > 4'd4) sh[11:8]  = sh[11:8]  + 4'd3;
         if (sh[15:12] > 4'd4) sh[15:12] = sh[15:12] + 4'd3;
         if (sh[19:16] > 4'd4) sh[19:16] = sh[19:16] + 4'd3;
         sh = sh << 1;
      end
      hundreds = sh[19:16];
      tens     = sh[15:12];
      ones     = sh[11:8];
   end

endmodule

// File: rtl/mode_countdown_timer.sv
// Hurricane / self-clean countdown timer fed by the hood mode FSM.
// Optional feature macro HURRICANE_COOLDOWN_EN: a locked-out hurricane mode
// re-arms after COOLDOWN_S seconds spent continuously in standby. Without it
// the lockout holds until a power cycle.
// dbg_state exposes the timer FSM state for observation.
module mode_countdown_timer
   import mode_countdown_timer_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 100_000_000,
   parameter int unsigned HURRICANE_S = 60,
`ifdef HURRICANE_COOLDOWN_EN
   parameter int unsigned COOLDOWN_S  = 30,
`endif
   parameter int unsigned CLEAN_S     = 180
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               machine_state,
   input  logic [2:0]         mode_state,
   input  logic               menu_btn,
   output logic               hurricane_mode_enabled,
   output logic               return_state,
   output logic               timer_active,
   output logic [7:0]         remaining_s,
   output logic [BCD_W-1:0]   bcd_h,
   output logic [BCD_W-1:0]   bcd_t,
   output logic [BCD_W-1:0]   bcd_o,
   output logic               done_pulse,
   output timer_state_t       dbg_state
);

   localparam int unsigned     PSC_W    = cnt_width(CLK_HZ);
   localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(CLK_HZ - 1);

   timer_state_t     state_q, state_d;
   logic [PSC_W-1:0] psc_q, psc_d;
   logic [7:0]       rem_q, rem_d;
   logic             ret_q, ret_d;
   logic             en_q, en_d;
   logic             done_q, done_d;
   logic [2:0]       mode_prev_q;
   logic             menu_prev_q;
   logic             timer_run, psc_run, tick;
   logic             hur_entry, cln_entry, menu_rise;
   logic [BCD_W-1:0] conv_h, conv_t, conv_o;
`ifdef HURRICANE_COOLDOWN_EN
   logic [7:0]       cd_q, cd_d;
`endif

   assign timer_run = (state_q == ST_RUN_HUR) || (state_q == ST_RUN_CLN);
`ifdef HURRICANE_COOLDOWN_EN
   assign psc_run   = timer_run || ((state_q == ST_IDLE) && !en_q);
`else
   assign psc_run   = timer_run;
`endif
   assign tick      = psc_run && (psc_q == PSC_LAST);
   assign hur_entry = (mode_state == MODE_HURRICANE) && (mode_prev_q != MODE_HURRICANE);
   assign cln_entry = (mode_state == MODE_CLEAN) && (mode_prev_q != MODE_CLEAN);
   assign menu_rise = menu_btn && !menu_prev_q;

   // Next-state, countdown and flag logic; power-off overrides everything.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      ret_d   = ret_q;
      en_d    = en_q;
      done_d  = 1'b0;
      psc_d   = (!psc_run || tick) ? '0 : psc_q + 1'b1;
`ifdef HURRICANE_COOLDOWN_EN
      cd_d    = cd_q;
`endif
      case (state_q)
         ST_IDLE: begin
            if (hur_entry && en_q) begin
               state_d = ST_RUN_HUR;
               rem_d   = 8'(HURRICANE_S);
               ret_d   = 1'b0;
            end else if (cln_entry) begin
               state_d = ST_RUN_CLN;
               rem_d   = 8'(CLEAN_S);
            end
`ifdef HURRICANE_COOLDOWN_EN
            else if (!en_q) begin
               if (mode_state != MODE_STANDBY) begin
                  cd_d  = '0;
                  psc_d = '0;
               end else if (tick) begin
                  if (cd_q == 8'(COOLDOWN_S - 1)) begin
                     en_d = 1'b1;
                     cd_d = '0;
                  end else begin
                     cd_d = cd_q + 1'b1;
                  end
               end
            end
`endif
         end
         ST_RUN_HUR: begin
            if (mode_state != MODE_HURRICANE) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end else begin
               if (tick) begin
                  if (rem_q == 8'd1) begin
                     rem_d  = '0;
                     done_d = 1'b1;
                  end else begin
                     rem_d  = rem_q - 1'b1;
                  end
               end
               // A press freezes the count unless it lands on the final tick.
               if (menu_rise) begin
                  ret_d   = 1'b1;
                  en_d    = 1'b0;
                  state_d = ST_HUR_DONE;
                  rem_d   = (tick && rem_q == 8'd1) ? 8'd0 : rem_q;
               end else if (tick && rem_q == 8'd1) begin
                  ret_d   = 1'b0;
                  en_d    = 1'b0;
                  state_d = ST_HUR_DONE;
               end
            end
         end
         ST_RUN_CLN: begin
            if (mode_state != MODE_CLEAN) begin
               state_d = ST_IDLE;
               rem_d   = '0;
            end else if (tick) begin
               if (rem_q == 8'd1) begin
                  rem_d   = '0;
                  done_d  = 1'b1;
                  state_d = ST_IDLE;
               end else begin
                  rem_d   = rem_q - 1'b1;
               end
            end
         end
         ST_HUR_DONE: begin
            en_d = 1'b0;
            if (mode_state != MODE_HURRICANE) begin
               ret_d   = 1'b0;
               rem_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) begin
         psc_d = '0;
`ifdef HURRICANE_COOLDOWN_EN
         cd_d  = '0;
`endif
      end
      if (!machine_state) begin
         state_d = ST_IDLE;
         rem_d   = '0;
         ret_d   = 1'b0;
         en_d    = 1'b1;
         done_d  = 1'b0;
         psc_d   = '0;
`ifdef HURRICANE_COOLDOWN_EN
         cd_d    = '0;
`endif
      end
   end

   // State, countdown and edge-detect registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         psc_q       <= '0;
         rem_q       <= '0;
         ret_q       <= 1'b0;
         en_q        <= 1'b1;
         done_q      <= 1'b0;
         mode_prev_q <= MODE_STANDBY;
         menu_prev_q <= 1'b0;
`ifdef HURRICANE_COOLDOWN_EN
         cd_q        <= '0;
`endif
      end else begin
         state_q     <= state_d;
         psc_q       <= psc_d;
         rem_q       <= rem_d;
         ret_q       <= ret_d;
         en_q        <= en_d;
         done_q      <= done_d;
         mode_prev_q <= machine_state ? mode_state : MODE_STANDBY;
         menu_prev_q <= machine_state ? menu_btn : 1'b0;
`ifdef HURRICANE_COOLDOWN_EN
         cd_q        <= cd_d;
`endif
      end
   end

   bin8_to_bcd u_bcd (
      .bin      (rem_q),
      .hundreds (conv_h),
      .tens     (conv_t),
      .ones     (conv_o)
   );

   // BCD digits trail remaining_s by one cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bcd_h <= '0;
         bcd_t <= '0;
         bcd_o <= '0;
      end else if (!machine_state) begin
         bcd_h <= '0;
         bcd_t <= '0;
         bcd_o <= '0;
      end else begin
         bcd_h <= conv_h;
         bcd_t <= conv_t;
         bcd_o <= conv_o;
      end
   end

   assign hurricane_mode_enabled = en_q;
   assign return_state           = ret_q;
   assign timer_active           = timer_run;
   assign remaining_s            = rem_q;
   assign done_pulse             = done_q;
   assign dbg_state              = state_q;

endmodule
